// File: rtl/ysyx_23060072_lsu_pkg.sv
// Shared encodings for the LSU stage: access-size codes, FSM states and
// the alignment rule used by the optional misalignment check
// (enabled by defining LSU_MISALIGN_CHECK_EN).
package ysyx_23060072_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE     = 2'b00,
        LSU_HALF     = 2'b01,
        LSU_WORD     = 2'b10,
        LSU_WORD_ALT = 2'b11   // reserved code, behaves as a word access
    } lsu_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Half accesses need a[0]=0, word accesses need a[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] lsu_type, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (lsu_type_e'(lsu_type))
            LSU_BYTE: bad = 1'b0;
            LSU_HALF: bad = addr_lo[0];
            default:  bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060072_lsu_align.sv
// Lane steering for the LSU: store data replication and byte strobes,
// plus load byte/half extraction with sign or zero extension.
module ysyx_23060072_lsu_align
    import ysyx_23060072_lsu_pkg::*;
(
    input  logic [1:0]  lsu_type,
    input  logic        lsu_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Pick the addressed lane, then replicate/extend according to the access size.
    always_comb begin
        load_byte  = load_word[{addr_lo, 3'b000} +: 8];
        load_half  = load_word[{addr_lo[1], 4'b0000} +: 16];
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
        load_data  = load_word;
        case (lsu_type_e'(lsu_type))
            LSU_BYTE: begin
                lane_wdata = {4{store_data[7:0]}};
                lane_wstrb = 4'b0001 << addr_lo;
                load_data  = {{24{lsu_signed & load_byte[7]}}, load_byte};
            end
            LSU_HALF: begin
                lane_wdata = {2{store_data[15:0]}};
                lane_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                load_data  = {{16{lsu_signed & load_half[15]}}, load_half};
            end
            default: begin
                lane_wdata = store_data;
                lane_wstrb = 4'b1111;
                load_data  = load_word;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060072_lsu_stage.sv
// LSU pipeline stage: IDLE/REQ/DONE handshake with the data bus, stalls the
// front end while an access is outstanding and registers write-back results.
// Optional: define LSU_MISALIGN_CHECK_EN to suppress misaligned half/word
// accesses and flag them on lsu_misalign_o during DONE.
module ysyx_23060072_lsu_stage
    import ysyx_23060072_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_flag_i,
    input  logic [1:0]  LSU_type_i,
    input  logic        store_flag_i,
    input  logic        load_flag_i,
    input  logic        LSU_signed_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_imm_i,
    input  logic [31:0] wb_data_ex_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        lsu_hold_flag_o,
    output logic        lsu_misalign_o,
    output logic        wb_flag_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o
);

    lsu_state_e  state, state_nxt;
    logic        mem_op;
    logic        is_store;
    logic        misalign_now;
    logic [31:0] addr;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] load_data;

    assign mem_op   = load_flag_i | store_flag_i;
    assign is_store = store_flag_i & ~load_flag_i;   // load wins when both are set
    assign addr     = operand_a_i + operand_imm_i;   // carry out dropped: wraps mod 2^32

    ysyx_23060072_lsu_align u_align (
        .lsu_type   (LSU_type_i),
        .lsu_signed (LSU_signed_i),
        .addr_lo    (addr[1:0]),
        .store_data (operand_b_i),
        .load_word  (mem_rdata_i),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .load_data  (load_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q;

    assign misalign_now   = is_misaligned(LSU_type_i, addr[1:0]);
    assign lsu_misalign_o = misalign_q & (state == ST_DONE);

    // Remember why IDLE skipped straight to DONE so DONE can report it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (state == ST_IDLE)
            misalign_q <= mem_op & misalign_now;
    end
`else
    assign misalign_now   = 1'b0;
    assign lsu_misalign_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state; DONE always returns to IDLE so the held input is consumed once.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mem_op) state_nxt = misalign_now ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_ready_i) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus and stall outputs; gated by rst_n so reset silences them at once.
    always_comb begin
        mem_req_o       = rst_n & (state == ST_REQ);
        lsu_hold_flag_o = rst_n & (((state == ST_IDLE) & mem_op) | (state == ST_REQ));
        mem_we_o        = mem_req_o & is_store;
        mem_wstrb_o     = (mem_req_o & is_store) ? lane_wstrb : 4'b0000;
        mem_wdata_o     = lane_wdata;
        mem_addr_o      = addr;
    end

    // Write-back registers: pass-through in IDLE, load result on bus accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_flag_o <= 1'b0;
            wb_addr_o <= 5'd0;
            wb_data_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        wb_flag_o <= 1'b0;
                    end else begin
                        wb_flag_o <= wb_flag_i;
                        wb_addr_o <= wb_addr_i;
                        wb_data_o <= wb_data_ex_i;
                    end
                end
                ST_REQ: begin
                    if (mem_ready_i) begin
                        wb_flag_o <= wb_flag_i & load_flag_i;
                        wb_addr_o <= wb_addr_i;
                        wb_data_o <= load_flag_i ? load_data : 32'd0;
                    end else begin
                        wb_flag_o <= 1'b0;
                    end
                end
                default: wb_flag_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/ysyx_23060072_lsu_stage.md
YSYX_23060072_LSU_STAGE -- requirements
Module: ysyx_23060072_lsu_stage
Interface (clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n)
REQ-001 clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 wb_flag_i  in  1  registered write-back enable from ex_stage.
REQ-004 LSU_type_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-005 store_flag_i  in  1  store instruction present.
REQ-006 load_flag_i  in  1  load instruction present; if it is asserted together with store_flag_i, the load takes priority.
REQ-007 LSU_signed_i  in  1  1 = sign-extend, 0 = zero-extend the loaded data.
REQ-008 wb_addr_i  in  5  destination register.
REQ-009 operand_a_i  in  32  base address.
REQ-010 operand_b_i  in  32  store data.
REQ-011 operand_imm_i  in  32  address offset.
REQ-012 wb_data_ex_i  in  32  ex_stage result for non-memory instructions.
REQ-013 mem_req_o  out  1  bus request; held high until it is accepted.
REQ-014 mem_we_o  out  1  1 = store.
REQ-015 mem_addr_o  out  32  byte address = operand_a_i + operand_imm_i, modulo 2^32.
REQ-016 mem_wdata_o  out  32  store data replicated across lanes: byte {4{b[7:0]}}, half {2{b[15:0]}}.
REQ-017 mem_wstrb_o  out  4  byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111; 0000 for loads.
REQ-018 mem_ready_i  in  1  accept strobe; the request completes in the cycle mem_req_o && mem_ready_i.
REQ-019 mem_rdata_i  in  32  load word; valid only in the completing cycle.
REQ-020 lsu_hold_flag_o  out  1  to controller; stalls ex_stage and earlier stages.
REQ-021 lsu_misalign_o  out  1  misaligned-access indication to controller.
REQ-022 wb_flag_o, wb_addr_o, wb_data_o  out  1/5/32  registered outputs to the wb stage.
Function
REQ-023 The FSM SHALL have states IDLE, REQ and DONE.
REQ-024 IDLE, no memory operation: wb_* load wb_flag_i, wb_addr_i and wb_data_ex_i each cycle; hold is 0.
REQ-025 IDLE with load or store: lsu_hold_flag_o=1 combinationally; wb_flag_o<=0; next state REQ.
REQ-026 REQ: mem_req_o=1 and lsu_hold_flag_o=1; mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o are derived combinationally from the held inputs.
REQ-027 REQ, mem_ready_i=0: stay in REQ; wb_flag_o<=0; bus outputs remain stable.
REQ-028 REQ, mem_ready_i=1: wb_data_o<=aligned/extended load data, or 0 for a store; wb_flag_o<=wb_flag_i&load_flag_i; wb_addr_o<=wb_addr_i; next state DONE.
REQ-029 DONE: hold=0 so ex_stage advances at the end of this cycle; the still-present input is treated as consumed; wb_flag_o<=0; next state IDLE.
REQ-030 Load extraction: byte = rdata[8*a[1:0]+:8]; half = rdata[16*a[1]+:16]; result extended per LSU_signed_i.
REQ-031 Minimum memory-operation occupancy SHALL be 3 cycles (IDLE, REQ, DONE) with zero bus wait; each wait cycle adds one.
REQ-032 mem_req_o SHALL never be asserted outside REQ.
REQ-033 Address addition SHALL wrap at 0xFFFFFFFF; the carry is discarded.
Reset
REQ-034 On rst_n low, immediately and independent of clk: state=IDLE; mem_req_o, lsu_hold_flag_o, lsu_misalign_o, wb_flag_o=0; wb_addr_o=0; wb_data_o=0. Asserting reset during REQ drops the request at once and discards the access.
Configuration
REQ-035 Macro LSU_MISALIGN_CHECK_EN defined: a half access with a[0]=1, or a word access with a[1:0]!=0, goes IDLE->DONE with no bus request; lsu_misalign_o=1 during DONE only; wb_flag_o=0.
REQ-036 Macro LSU_MISALIGN_CHECK_EN undefined: lsu_misalign_o is tied to 0; every access is issued as computed, with no check.
Structure
REQ-037 LSU_type encodings and FSM state encodings SHALL live in the shared package/define file.
REQ-038 Store lane/strobe generation and load extraction SHALL be one combinational sub-module, ysyx_23060072_lsu_align.
Verification
REQ-039 Non-memory stream, wb_data_ex_i=0x1234: wb_data_o=0x1234 next cycle; hold never asserts.
REQ-040 lb, a=0x1003, rdata=0x80FFFFFF, ready on first REQ cycle, signed: wb_data_o=0xFFFFFF80; hold high for exactly 2 cycles.
REQ-041 sh, a=0x2002, b=0xABCD: wstrb=1100, wdata=0xABCDABCD, we=1; ready held low 3 cycles -> mem_req_o high for 4 cycles.
REQ-042 lhu, a=0xFFFFFFFC, imm=6: mem_addr_o=0x00000002; rdata=0xBEEF0000 -> wb_data_o=0x0000BEEF.
REQ-043 rst_n pulled low mid-REQ: mem_req_o drops the same cycle; after release the FSM is in IDLE and wb_flag_o=0.
REQ-044 lw, a=0x1001 with LSU_MISALIGN_CHECK_EN: no request is issued and lsu_misalign_o pulses 1 cycle; without the macro, a request is issued with wstrb=0000.
